// File: rtl/coax_rx_buffer.sv
// coax_rx_buffer: receive FIFO between coax_rx and the host reader.
// Buffers 10-bit received words, latches the first receive error code,
// flags overflow, and kicks coax_rx back to idle after a receive error.
module coax_rx_buffer #(
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 rx_data,
    input  logic                       rx_strobe,
    input  logic                       rx_error,
    output logic                       rx_reset,
    input  logic                       read_strobe,
    input  logic                       clear,
    output logic [9:0]                 data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       error,
    output logic [9:0]                 error_code,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        STATE_NORMAL = 1'b0,
        STATE_ERROR  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nx;
    logic [AW:0]     count_nx;
    logic            err_prev;
    logic            err_det, do_wr, do_rd, do_ovf, wr_en;

    // Next-state and per-cycle write/read/error decisions.
    always_comb begin
        state_d   = state_q;
        err_det   = 1'b0;
        do_wr     = 1'b0;
        do_ovf    = 1'b0;
        do_rd     = read_strobe & ~empty;
        rd_ptr_nx = rd_ptr + AW'(1);
        if (state_q == STATE_NORMAL) begin
            // Error detection outranks the write in the same cycle.
            err_det = rx_error & ~err_prev;
            if (!err_det && rx_strobe) begin
                // A full FIFO still accepts the word if a read frees a slot.
                do_wr  = ~full | read_strobe;
                do_ovf = full & ~read_strobe;
            end
        end
        if (clear)
            state_d = STATE_NORMAL;
        else if (err_det || do_ovf)
            state_d = STATE_ERROR;
        wr_en = do_wr & ~clear & ~reset;
        count_nx = count;
        case ({do_wr, do_rd})
            2'b10:   count_nx = count + (AW+1)'(1);
            2'b01:   count_nx = count - (AW+1)'(1);
            default: count_nx = count;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= STATE_NORMAL;
        else
            state_q <= state_d;
    end

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_data;
    end

    // Pointers, occupancy, registered head word and error flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            data       <= '0;
            error      <= 1'b0;
            overflow   <= 1'b0;
            error_code <= '0;
            rx_reset   <= 1'b0;
            // Forgetting the last level makes a still-high rx_error count as new.
            err_prev   <= 1'b0;
        end else begin
            err_prev <= rx_error;
            rx_reset <= err_det;
            if (err_det) begin
                error      <= 1'b1;
                error_code <= rx_data;
            end
            if (do_ovf) begin
                error    <= 1'b1;
                overflow <= 1'b1;
            end
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr_nx;
            count <= count_nx;
            empty <= (count_nx == '0);
            full  <= (count_nx == (AW+1)'(DEPTH));
            // Head word: next slot after a pop, or the incoming word when it
            // lands in an empty queue (it is not in mem yet this cycle).
            if (do_rd) begin
                if (count > (AW+1)'(1))
                    data <= mem[rd_ptr_nx];
                else if (do_wr)
                    data <= rx_data;
            end else if (do_wr && empty) begin
                data <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Self-checking bench for coax_rx_buffer: queue-based reference model,
// scoreboard of popped words checked by an independent monitor.
module tb_coax_rx_buffer;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0, rx_strobe = 1'b0, rx_error = 1'b0;
    logic        read_strobe = 1'b0, clear = 1'b0;
    logic [9:0]  rx_data = '0;
    logic        rx_reset, empty, full, error, overflow;
    logic [9:0]  data, error_code;
    logic [$clog2(D):0] count;

    coax_rx_buffer #(.DEPTH(D)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .rx_error(rx_error), .rx_reset(rx_reset), .read_strobe(read_strobe),
        .clear(clear), .data(data), .empty(empty), .full(full), .count(count),
        .error(error), .error_code(error_code), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int pulses = 0, exp_pulses = 0;

    // reference model state
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    bit         m_err, m_ovf, m_mode, m_prev;
    logic [9:0] m_code;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every accepted pop must present the scoreboard's next word.
    always @(negedge clk) begin
        if (rx_reset) pulses++;
        if (!reset && !clear && read_strobe && !empty) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", int'(data), int'(exp_q.pop_front()));
        end
    end

    task automatic step(input bit wr, input bit rd, input bit clr, input bit rxe,
                        input bit rst, input logic [9:0] din);
        bit rise, rd_ok;
        reset = rst; clear = clr; rx_strobe = wr; read_strobe = rd;
        rx_error = rxe; rx_data = din;
        if (rst || clr) begin
            mq.delete();
            m_err = 0; m_ovf = 0; m_mode = 0; m_prev = 0; m_code = '0;
        end else begin
            rise   = !m_mode && rxe && !m_prev;
            m_prev = rxe;
            rd_ok  = rd && mq.size() > 0;
            if (rd_ok) exp_q.push_back(mq[0]);
            if (rise) begin
                m_err = 1; m_code = din; m_mode = 1; exp_pulses++;
            end else if (wr && !m_mode) begin
                if (mq.size() < D || rd_ok) mq.push_back(din);
                else begin m_ovf = 1; m_err = 1; m_mode = 1; end
            end
            if (rd_ok) void'(mq.pop_front());
        end
        @(posedge clk); #1;
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == D));
        chk("error", int'(error), int'(m_err));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("error_code", int'(error_code), int'(m_code));
        if (mq.size() > 0) chk("head", int'(data), int'(mq[0]));
        if (rst) begin
            chk("rst_data", int'(data), 0);
            chk("rst_rx_reset", int'(rx_reset), 0);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        m_code = '0;
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);

        // basic write/read ordering
        step(1, 0, 0, 0, 0, 10'b0110110011);
        step(1, 0, 0, 0, 0, 10'b1000000001);
        step(0, 1, 0, 0, 0, '0);
        chk("basic_data", int'(data), int'(10'b1000000001));
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);          // read on empty ignored

        // fill, overflow, drain
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0, 10'(100 + i));
        step(1, 0, 0, 0, 0, 10'h3ff);
        step(1, 0, 0, 0, 0, 10'h3fe);     // ignored in error state
        idle();
        chk("ovf_no_rx_reset", pulses, exp_pulses);
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0, '0);

        // full with simultaneous write and read
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0, 10'(200 + i));
        step(1, 1, 0, 0, 0, 10'h155);
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0, '0);
        chk("last_word", int'(data), int'(10'h155));

        // receive error path
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 10'(300 + i));
        step(0, 0, 0, 1, 0, 10'h002);
        step(1, 0, 0, 0, 0, 10'h0aa);
        step(0, 0, 0, 1, 0, 10'h0bb);
        idle();
        chk("rx_reset_pulses", pulses, exp_pulses);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, '0);

        // clear while in error with 5 words, then normal write
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 10'(400 + i));
        step(0, 0, 0, 1, 0, 10'h077);
        step(1, 0, 1, 0, 0, 10'h111);     // write coincident with clear dropped
        step(1, 0, 0, 0, 0, 10'h222);
        step(0, 1, 0, 0, 0, '0);

        // rx_error held through clear re-triggers
        step(0, 0, 0, 1, 0, 10'h033);
        step(0, 0, 1, 1, 0, 10'h044);
        step(0, 0, 0, 1, 0, 10'h055);
        idle();
        chk("retrigger_pulses", pulses, exp_pulses);

        // interleaved write/read pairs across pointer wrap
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 2 * D + 3; i++) begin
            step(1, 0, 0, 0, 0, 10'($urandom));
            step(0, 1, 0, 0, 0, '0);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 10'($urandom));
        step(1, 1, 0, 0, 1, 10'h3c3);     // reset mid-stream
        step(1, 0, 0, 0, 0, 10'h2a5);
        step(0, 1, 0, 0, 0, '0);

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 4),
                 1'($urandom_range(0, 99) < 1), 10'($urandom));
        end
        step(0, 0, 0, 0, 0, '0);
        idle();
        chk("final_pulses", pulses, exp_pulses);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
